// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath width and the fetch-to-decode queue entry.
package cpu_pkg;
  localparam int unsigned DBITS = 32;

  typedef struct packed {
    logic [DBITS-1:0] pc;
    logic [DBITS-1:0] pc_added;
    logic [DBITS-1:0] instr;
  } entry_t;
endpackage

// File: rtl/queue_mem.sv
// Instruction queue storage: one synchronous write port, one combinational read port.
import cpu_pkg::*;

module queue_mem #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);
  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction FIFO with flush; define INSTR_QUEUE_BYPASS_EN to let
// an instruction reach decode in the same cycle when the queue is empty.
import cpu_pkg::*;

module instr_queue #(
  parameter int unsigned DBITS = cpu_pkg::DBITS,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DBITS-1:0]         in_pc,
  input  logic [DBITS-1:0]         in_pc_added,
  input  logic [DBITS-1:0]         in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DBITS-1:0]         out_pc,
  output logic [DBITS-1:0]         out_pc_added,
  output logic [DBITS-1:0]         out_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          empty, bypass, push, pop;
  entry_t        wr_entry, head;

  assign empty    = (count == '0);
  assign in_ready = (count < FULL);

`ifdef INSTR_QUEUE_BYPASS_EN
  // Gated by reset so out_valid stays low while reset is held.
  assign bypass = reset && empty && in_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry taken by decode this cycle never enters storage.
  assign push = in_valid && in_ready && !flush && !(bypass && out_ready);
  assign pop  = !empty && out_ready && !flush;

  assign out_valid = !empty || bypass;

  assign wr_entry.pc       = in_pc;
  assign wr_entry.pc_added = in_pc_added;
  assign wr_entry.instr    = in_instr;

  queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_comb begin
    out_pc       = '0;
    out_pc_added = '0;
    out_instr    = '0;
    if (!empty) begin
      out_pc       = head.pc;
      out_pc_added = head.pc_added;
      out_instr    = head.instr;
    end else if (bypass) begin
      out_pc       = in_pc;
      out_pc_added = in_pc_added;
      out_instr    = in_instr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue against a queue-based reference model.
module tb_instr_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_added;
    logic [31:0] instr;
  } tb_entry_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_pc_added, in_instr;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_pc_added, out_instr;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  tb_entry_t q[$];

  instr_queue #(.DBITS(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_added(in_pc_added), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_added(out_pc_added), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic bit m_bypass();
`ifdef INSTR_QUEUE_BYPASS_EN
    return reset && q.size() == 0 && in_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic tb_entry_t m_head();
    if (q.size() != 0) return q[0];
    if (m_bypass()) return '{in_pc, in_pc_added, in_instr};
    return '0;
  endfunction

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    in_valid    = v;
    in_pc       = pc;
    in_pc_added = pc + 32'd4;
    in_instr    = $urandom;
    out_ready   = rdy;
    flush       = fl;
  endtask

  // Advance one clock edge, applying the FIFO rules to the model.
  task automatic step();
    bit byp, do_pop, do_push;
    tb_entry_t e;
    byp     = m_bypass();
    do_pop  = q.size() != 0 && out_ready && !flush;
    do_push = in_valid && q.size() < DEPTH && !flush && !(byp && out_ready);
    e = '{in_pc, in_pc_added, in_instr};
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 32'h40, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_instr !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b count=%0d out_instr=%h, required 1 0 0 0",
               in_ready, out_valid, count, out_instr);
    end
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    // Mid-operation reset discards in-flight entries.
    drive(1, 32'h10, 0, 0); step();
    drive(1, 32'h14, 0, 0); step();
    drive(0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    q.delete();
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: count=%0d out_valid=%b out_pc=%h, required 0 0 0", count, out_valid, out_pc);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1, 32'h90, 0, 0); step();
    drive(0, 0, 0, 0); #1;
    checks++;
    if (count !== 3'd1 || out_pc !== 32'h90 || out_pc_added !== 32'h94) begin
      failures++;
      $display("FAIL reset_first_push: count=%0d out_pc=%h out_pc_added=%h, required 1 00000090 00000094",
               count, out_pc, out_pc_added);
    end
    drive(0, 0, 1, 0); step();
  endtask

  task automatic test_fill();
    tb_entry_t h;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h40 + 32'(4 * i), 0, 0); step();
    end
    drive(1, 32'h50, 0, 0); #1;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: count=%0d in_ready=%b, required 4 0", count, in_ready);
    end
    step();
    drive(0, 0, 0, 0); #1;
    h = m_head();
    checks++;
    if (count !== 3'd4 || out_pc !== 32'h40 || out_instr !== h.instr) begin
      failures++;
      $display("FAIL fill_refused: count=%0d out_pc=%h out_instr=%h, required 4 00000040 %h",
               count, out_pc, out_instr, h.instr);
    end
  endtask

  task automatic test_full_push_pop();
    drive(1, 32'h54, 1, 0); #1;
    checks++;
    if (in_ready !== 1'b0 || out_pc !== 32'h40) begin
      failures++;
      $display("FAIL full_pp_stall: in_ready=%b out_pc=%h, required 0 00000040", in_ready, out_pc);
    end
    step();
    drive(0, 0, 0, 0); #1;
    checks++;
    if (count !== 3'd3 || out_pc !== 32'h44 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pp_after: count=%0d out_pc=%h in_ready=%b, required 3 00000044 1", count, out_pc, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0); #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h44 + 32'(4 * i)) begin
        failures++;
        $display("FAIL full_pp_drain: out_valid=%b out_pc=%h, required 1 %h", out_valid, out_pc, 32'h44 + 32'(4 * i));
      end
      step();
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0 || out_pc !== 32'd0) begin
      failures++;
      $display("FAIL full_pp_lost: out_valid=%b count=%0d out_pc=%h, required 0 0 0", out_valid, count, out_pc);
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    int budget = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h40 + 32'(4 * i), 1, 0); #1;
      checks++;
      if (out_valid !== ((i > 0) || m_bypass())) begin
        failures++;
        $display("FAIL wrap_gap[%0d]: out_valid=%b, required %b", i, out_valid, (i > 0) || m_bypass());
      end
      if (out_valid) begin
        checks++;
        if (out_pc !== 32'h40 + 32'(4 * k)) begin
          failures++;
          $display("FAIL wrap_seq[%0d]: out_pc=%h, required %h", k, out_pc, 32'h40 + 32'(4 * k));
        end
        k++;
      end
      step();
    end
    drive(0, 0, 1, 0); #1;
    while (out_valid && budget < 8) begin
      checks++;
      if (out_pc !== 32'h40 + 32'(4 * k)) begin
        failures++;
        $display("FAIL wrap_seq[%0d]: out_pc=%h, required %h", k, out_pc, 32'h40 + 32'(4 * k));
      end
      k++;
      budget++;
      step(); #1;
    end
    checks++;
    if (k !== 10 || count !== 3'd0) begin
      failures++;
      $display("FAIL wrap_total: popped=%0d count=%0d, required 10 0", k, count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hA0 + 32'(4 * i), 0, 0); step();
    end
    drive(1, 32'hAC, 1, 1); step();
    drive(0, 0, 0, 0); #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: count=%0d out_valid=%b, required 0 0", count, out_valid);
    end
    drive(1, 32'h80, 0, 0); step();
    drive(0, 0, 0, 0); #1;
    checks++;
    if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h80) begin
      failures++;
      $display("FAIL flush_next_push: count=%0d out_valid=%b out_pc=%h, required 1 1 00000080",
               count, out_valid, out_pc);
    end
    drive(0, 0, 1, 0); step();
  endtask

`ifdef INSTR_QUEUE_BYPASS_EN
  task automatic test_bypass();
    drive(1, 32'h40, 1, 0); #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_pc_added !== 32'h44 || out_instr !== in_instr) begin
      failures++;
      $display("FAIL bypass_same_cycle: out_valid=%b out_pc=%h out_pc_added=%h, required 1 00000040 00000044",
               out_valid, out_pc, out_pc_added);
    end
    step();
    drive(0, 0, 0, 0); #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bypass_not_stored: count=%0d out_valid=%b, required 0 0", count, out_valid);
    end
  endtask
`endif

  task automatic test_random();
    tb_entry_t h;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
      #1;
      h = m_head();
      checks++;
      if (out_valid !== (q.size() != 0 || m_bypass()) || in_ready !== (q.size() < DEPTH) ||
          int'(count) !== q.size() || out_pc !== h.pc || out_pc_added !== h.pc_added ||
          out_instr !== h.instr) begin
        failures++;
        $display("FAIL random[%0d]: valid=%b ready=%b count=%0d pc=%h pca=%h instr=%h, required %b %b %0d %h %h %h",
                 i, out_valid, in_ready, count, out_pc, out_pc_added, out_instr,
                 q.size() != 0 || m_bypass(), q.size() < DEPTH, q.size(), h.pc, h.pc_added, h.instr);
      end
      step();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0);
    test_reset();
    test_fill();
    test_full_push_pop();
    test_wrap();
    test_flush();
`ifdef INSTR_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DBITS, default 32: width of the PC and instruction fields.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: discards all queued entries (taken branch or jal redirect).
REQ-006 SHALL have port in_valid, input, 1 bit: fetch presents a new instruction.
REQ-007 SHALL have port in_ready, output, 1 bit: queue can accept; fetch drives its PC write enable from this.
REQ-008 SHALL have port in_pc, input, DBITS bits: PC of the fetched instruction.
REQ-009 SHALL have port in_pc_added, input, DBITS bits: PC+4 from fetch.
REQ-010 SHALL have port in_instr, input, DBITS bits: instruction word.
REQ-011 SHALL have port out_valid, output, 1 bit: head entry is valid for decode.
REQ-012 SHALL have port out_ready, input, 1 bit: decode consumes the head entry this cycle.
REQ-013 SHALL have ports out_pc, out_pc_added and out_instr, outputs, DBITS bits each: fields of the head entry.
REQ-014 SHALL have port count, output, clog2(DEPTH)+1 bits: number of stored entries.

Function
REQ-015 SHALL operate as a FIFO: a push occurs when in_valid && in_ready && !flush; a pop occurs when out_valid && out_ready && !flush.
REQ-016 SHALL drive in_ready = (count < DEPTH), decoded from registered state only.
REQ-017 SHALL update count by +1 on push only, -1 on pop only, and hold it when push and pop occur in the same cycle.
REQ-018 SHALL keep read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH with no gap or stall at wrap.
REQ-019 SHALL give a stored entry a minimum latency of 1 cycle: pushed at edge N, it is visible on out_* after edge N.
REQ-020 SHALL, when full, refuse a push even if a pop occurs in the same cycle; the pop still occurs.
REQ-021 SHALL, when flush=1, set count and both pointers to 0 at the next edge and drop any push and pop in that cycle; flush has priority over all other events.
REQ-022 SHALL drive out_valid = (count != 0), plus the bypass term in REQ-028.
REQ-023 SHALL drive out_pc, out_pc_added and out_instr to 0 whenever out_valid=0.
REQ-024 SHALL hold the head entry stable on out_* while out_valid && !out_ready, until it is popped or flushed.

Reset
REQ-025 SHALL, while reset=0 and asynchronously to clk, force count=0, pointers=0, out_valid=0 and out_* data=0.
REQ-026 SHALL discard any entries in flight when reset is asserted mid-operation; the first push after reset release lands at index 0.
REQ-027 SHALL NOT require the storage array to be reset; its contents are not observable while empty.

Configuration
REQ-028 SHALL, when INSTR_QUEUE_BYPASS_EN is defined, present the in_* fields on out_* combinationally with out_valid=1 when count==0 && in_valid && !flush.
REQ-029 SHALL, under bypass, treat an entry as consumed without being stored if out_ready=1 in that cycle; if out_ready=0, the entry is pushed normally.
REQ-030 SHALL, when INSTR_QUEUE_BYPASS_EN is undefined, apply no bypass, so the minimum latency is 1 cycle.

Structure
REQ-031 SHALL take DBITS and the entry typedef {pc, pc_added, instr} from shared package cpu_pkg.
REQ-032 SHALL place the storage array in one sub-module, queue_mem: one synchronous write port and one combinational read port.

Verification
REQ-033 Bench SHALL cover reset: hold reset=0 with in_valid=1 -> in_ready=1, out_valid=0, count=0, out_instr=0.
REQ-034 Bench SHALL cover fill: push 4 entries (PC 0x40 to 0x4C) with out_ready=0 -> count=4 and in_ready=0; a fifth push is refused.
REQ-035 Bench SHALL cover full with simultaneous push and pop: push and pop together -> count becomes 3, head is 0x44, the pushed entry is lost and fetch stalls.
REQ-036 Bench SHALL cover wrap-around: 10 back-to-back push/pop pairs -> out_pc sequence 0x40, 0x44, ... with no gap, correct across pointer wrap.
REQ-037 Bench SHALL cover flush: flush=1 with count=3 and in_valid=1 -> count=0 and out_valid=0 at the next cycle; the next push of PC 0x80 appears at the head.
REQ-038 Bench SHALL cover bypass: with INSTR_QUEUE_BYPASS_EN defined, empty queue, in_valid=1, in_pc=0x40, out_ready=1 -> out_pc=0x40 in the same cycle and count stays 0.
